crack_dispatch: RTL

- Parametrised key-search scheduler for the ARC4 cracking datapath.
- Successor to the fixed two-engine crack top level: generalises to NCORES parallel crack engines and a programmable key range.
- Hands candidate keys in ascending order to idle engines and collects their pass/fail results.
- Reports the lowest matching key in the range, or "not found", through the team's rdy/en handshake.

---
 rtl/crack_dispatch.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/crack_dispatch.sv
// crack_dispatch: key-search scheduler for the ARC4 cracking datapath.
// Hands candidate keys from a programmable range, in ascending order, to
// NCORES parallel crack engines and reports the lowest key that decrypted
// to valid plaintext, or "not found".
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   en / rdy          start request / block idle or done (rdy/en handshake)
//   first_key         first candidate, sampled on en
//   last_key          last candidate (inclusive), sampled on en
//   found, key_out    result, valid while done; key_out is 0 when not found
//   core_rdy[i]       engine i idle and able to accept a key
//   core_en[i]        one-cycle start pulse to engine i
//   core_key          key for engine i in slice [i*KEY_W +: KEY_W]
//   core_done[i]      one-cycle completion pulse from engine i
//   core_hit[i]       qualifies core_done[i]: 1 = key matched
module crack_dispatch #(
  parameter int NCORES = 2,
  parameter int KEY_W  = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  output logic                    rdy,
  input  logic [KEY_W-1:0]        first_key,
  input  logic [KEY_W-1:0]        last_key,
  output logic                    found,
  output logic [KEY_W-1:0]        key_out,
  input  logic [NCORES-1:0]       core_rdy,
  output logic [NCORES-1:0]       core_en,
  output logic [NCORES*KEY_W-1:0] core_key,
  input  logic [NCORES-1:0]       core_done,
  input  logic [NCORES-1:0]       core_hit
);

  localparam int PTR_W = (NCORES > 1) ? $clog2(NCORES) : 1;

  typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} state_t;

  state_t             state, state_next;
  logic [KEY_W-1:0]   next_key;
  logic [KEY_W-1:0]   limit_key;
  logic [KEY_W-1:0]   best_key;
  logic               best_valid;
  logic               exhausted;
  logic [NCORES-1:0]  in_flight;
  logic [PTR_W-1:0]   rr_ptr;

  logic               start;
  logic               dispatch_ok;
  logic [NCORES-1:0]  avail;
  logic               hi_found, lo_found;
  logic [PTR_W-1:0]   hi_idx, lo_idx;
  logic [PTR_W-1:0]   grant_idx;
  logic               grant_valid;
  logic [NCORES-1:0]  grant_oh;
  logic [PTR_W-1:0]   ptr_next;
  logic [NCORES-1:0]  done_mask;
  logic               hit_valid;
  logic [KEY_W-1:0]   hit_key;

  assign start       = en && ((state == IDLE) || (state == DONE));
  assign dispatch_ok = (state == DISPATCH) && !exhausted && !best_valid;
  assign avail       = core_rdy & ~in_flight;
  // Results from engines not in flight (e.g. work issued before a reset)
  // are dropped here.
  assign done_mask   = (state != IDLE) ? (core_done & in_flight) : '0;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. DRAIN looks at the in-flight set as it will be after
  // this cycle's completions so rdy rises one cycle after the last done.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = (last_key < first_key) ? DONE : DISPATCH;
        end
      end
      DISPATCH: begin
        if (exhausted || best_valid) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if ((in_flight & ~done_mask) == '0) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    rdy     = (state == IDLE) || (state == DONE);
    found   = (state == DONE) && best_valid;
    key_out = found ? best_key : '0;
  end

  // Round-robin arbiter: the descending scan leaves the lowest free engine
  // at or above the pointer in hi_idx and the lowest free engine overall in
  // lo_idx, which is the wrap-around choice.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NCORES - 1; i >= 0; i--) begin
      if (avail[i]) begin
        lo_found = 1'b1;
        lo_idx   = PTR_W'(i);
        if (PTR_W'(i) >= rr_ptr) begin
          hi_found = 1'b1;
          hi_idx   = PTR_W'(i);
        end
      end
    end
    grant_idx   = hi_found ? hi_idx : lo_idx;
    grant_valid = dispatch_ok && (hi_found || lo_found);
    grant_oh    = '0;
    for (int i = 0; i < NCORES; i++) begin
      if (grant_valid && (PTR_W'(i) == grant_idx)) begin
        grant_oh[i] = 1'b1;
      end
    end
    ptr_next = (grant_idx == PTR_W'(NCORES - 1)) ? '0 : grant_idx + PTR_W'(1);
  end

  // Lowest key among all hits completing this cycle. An engine's core_key
  // slice is held until its next grant, and no grant can land on an engine
  // in flight, so the slice doubles as that engine's tag.
  always_comb begin
    hit_valid = 1'b0;
    hit_key   = '0;
    for (int i = 0; i < NCORES; i++) begin
      if (done_mask[i] && core_hit[i]) begin
        if (!hit_valid || (core_key[i*KEY_W +: KEY_W] < hit_key)) begin
          hit_valid = 1'b1;
          hit_key   = core_key[i*KEY_W +: KEY_W];
        end
      end
    end
  end

  // Datapath: key counter, limit, best hit, in-flight tracking, engine ports.
  // exhausted is set when the limit itself is granted, so the counter never
  // needs to count past the top of the key space.
  always_ff @(posedge clk) begin
    if (rst) begin
      next_key   <= '0;
      limit_key  <= '0;
      best_key   <= '0;
      best_valid <= 1'b0;
      exhausted  <= 1'b0;
      in_flight  <= '0;
      rr_ptr     <= '0;
      core_en    <= '0;
      core_key   <= '0;
    end else begin
      core_en   <= grant_oh;
      in_flight <= (in_flight & ~done_mask) | grant_oh;
      if (start) begin
        next_key   <= first_key;
        limit_key  <= last_key;
        best_key   <= '0;
        best_valid <= 1'b0;
        exhausted  <= 1'b0;
        rr_ptr     <= '0;
      end else begin
        if (grant_valid) begin
          next_key <= next_key + KEY_W'(1);
          rr_ptr   <= ptr_next;
          if (next_key == limit_key) begin
            exhausted <= 1'b1;
          end
        end
        if (hit_valid && (!best_valid || (hit_key < best_key))) begin
          best_valid <= 1'b1;
          best_key   <= hit_key;
        end
      end
      for (int i = 0; i < NCORES; i++) begin
        if (grant_oh[i]) begin
          core_key[i*KEY_W +: KEY_W] <= next_key;
        end
      end
    end
  end

endmodule
